turbo_iter_ctrl: RTL and testbench
==================================

Name: turbo_iter_ctrl

Overview:
Iteration scheduler for the turbo decoder's single shared SISO engine. Runs the engine through alternating half-iterations: half 0 in natural order (constituent 1), half 1 in interleaved order (constituent 2). For each half it drives the SISO's symbol read-address stream. It counts full iterations and stops at the programmed count or on early-stop convergence.

Parameters:
BLOCK_SIZE, 21, symbols per code block (N)
ADDR_W, 5, symbol address width, at least clog2(BLOCK_SIZE)
ITER_W, 4, iteration counter width
INTLV_A, 5, interleaver stride; must be coprime with BLOCK_SIZE and less than BLOCK_SIZE
INTLV_B, 3, interleaver offset; less than BLOCK_SIZE

Ports:
clk_p_i  in  1  clock, rising edge
reset_p_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle request to decode one block; honoured only in IDLE
num_iter_i  in  ITER_W  full iterations to run; sampled on an accepted start_i
abort_i  in  1  synchronous abort of the current decode
early_stop_i  in  1  SISO hard-decision-converged flag
siso_start_o  out  1  one-cycle pulse that opens a half-iteration
half_o  out  1  0 = natural order, 1 = interleaved order; stable while busy
iter_o  out  ITER_W  current full-iteration index, starting at 0
rd_addr_o  out  ADDR_W  symbol address presented to the SISO
rd_vld_o  out  1  rd_addr_o is valid
rd_rdy_i  in  1  SISO accepts the address
siso_done_i  in  1  one-cycle pulse when the SISO finishes a half
busy_o  out  1  decode in progress
done_o  out  1  one-cycle pulse at normal completion
err_o  out  1  sticky protocol error; cleared only by reset or an accepted start_i

Behaviour:
- Reset: state=IDLE; all outputs 0, including rd_addr_o, iter_o, half_o and err_o.
- FSM states: IDLE, START, STREAM, WAIT, DECIDE.
- IDLE:
  - start_i=1 latches num_iter_i; a value of 0 is latched as 1.
  - Same edge: clear iter, half and err_o; next state START.
  - busy_o=1 from the following cycle.
- START:
  - siso_start_o=1 for exactly one cycle; next state STREAM.
  - Symbol counter k cleared; interleave register p loaded with INTLV_B.
- STREAM:
  - rd_vld_o=1.
  - rd_addr_o = k when half_o=0, p when half_o=1.
  - On each rd_vld_o&&rd_rdy_i:
    - k increments.
    - p = p+INTLV_A, minus BLOCK_SIZE if the sum is at least BLOCK_SIZE. No multiplier; the adder is ADDR_W+1 bits.
  - When the transfer with k=BLOCK_SIZE-1 is accepted: next state WAIT, rd_vld_o=0 next cycle.
  - rd_vld_o stays high and rd_addr_o stays stable while rd_rdy_i=0.
- WAIT:
  - Outputs idle until siso_done_i, then next state DECIDE.
  - If half_o=1, early_stop_i is sampled on the siso_done_i cycle into stop_q.
  - early_stop_i is ignored at every other time.
- DECIDE (one cycle):
  - Finish condition: half_o=1 and (iter_o==num_iter-1 or stop_q).
  - On finish: done_o=1 this cycle; IDLE next; busy_o=0 next cycle; iter_o and half_o hold their final values until the next start.
  - If half_o=0: half_o becomes 1; next state START.
  - Otherwise (half_o=1, no finish): half_o becomes 0, iter_o increments; next state START.
- Latency:
  - start_i at cycle t gives siso_start_o at t+1 and the first rd_vld_o at t+2.
  - siso_done_i at cycle u gives DECIDE at u+1, and the next siso_start_o or done_o follows from it.
- Protocol error:
  - Trigger: siso_done_i in START or STREAM.
  - Response: err_o set (sticky); go to IDLE; no done_o; busy_o=0 next cycle.
  - siso_done_i in IDLE is ignored.
- abort_i:
  - In any busy state: IDLE next cycle; no done_o; rd_vld_o and busy_o drop next cycle; err_o unchanged.
  - abort_i has priority over siso_done_i and over the last STREAM transfer in the same cycle.
- start_i while busy_o=1 is ignored.
- reset_p_i mid-decode: immediate return to reset values; the SISO is expected to be reset by the same signal.

Decomposition:
- Shared package turbo_pkg:
  - FSM state enum.
  - Default constants BLOCK_SIZE=21, INTLV_A=5, INTLV_B=3, width constants.
  - All sibling turbo blocks use the same package.
- Sub-module turbo_intlv_addr:
  - Incremental modular address generator.
  - Ports: clear, advance, sel_intlv; output address.
  - The deinterleaver writeback path reuses it.

Test Plan:
1. Single iteration, num_iter_i=1, rd_rdy_i=1, siso_done_i 5 cycles after the last address:
   - siso_start_o at t+1.
   - Addresses 0..20 in half 0.
   - Half 1 addresses 3,8,13,18,2,7,12,17,1,6,11,16,0,5,10,15,20,4,9,14,19.
   - done_o one cycle after the second siso_done_i, with iter_o=0 and half_o=1.
2. Backpressure: rd_rdy_i toggles 1,0,0,1 repeatedly:
   - rd_addr_o holds through stalls.
   - Exactly 21 accepted transfers per half, no duplicate or skipped address.
3. num_iter_i=3 with early_stop_i=1 on the half-1 siso_done_i of iteration 1:
   - done_o after iteration 1 (iter_o=1).
   - Exactly 4 siso_start_o pulses.
4. num_iter_i=0:
   - Behaves as 1: exactly 2 siso_start_o pulses, then done_o.
5. siso_done_i asserted during STREAM at k=7:
   - err_o=1, busy_o=0 next cycle, no done_o.
   - A later start_i clears err_o and decodes normally.
6. Abort and reset:
   - abort_i during WAIT of iteration 2 gives IDLE next cycle, no done_o.
   - reset_p_i mid-STREAM forces all outputs to 0 asynchronously.
   - start_i while busy has no effect.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo decoder blocks: scheduler FSM states and
// default code-block / interleaver geometry.
package turbo_pkg;

   localparam int unsigned BLOCK_SIZE_DEF = 21;
   localparam int unsigned ADDR_W_DEF     = 5;
   localparam int unsigned ITER_W_DEF     = 4;
   localparam int unsigned INTLV_A_DEF    = 5;
   localparam int unsigned INTLV_B_DEF    = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_STREAM,
      ST_WAIT,
      ST_DECIDE
   } state_t;

endpackage

// File: rtl/turbo_intlv_addr.sv
// Incremental symbol address generator: natural index k and interleaved index
// p = (INTLV_B + k*INTLV_A) mod BLOCK_SIZE, stepped without a multiplier.
module turbo_intlv_addr
   import turbo_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned INTLV_A    = INTLV_A_DEF,
   parameter int unsigned INTLV_B    = INTLV_B_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   input  logic              sel_intlv,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W:0]   STRIDE = (ADDR_W+1)'(INTLV_A);
   localparam logic [ADDR_W:0]   MODULUS = (ADDR_W+1)'(BLOCK_SIZE);
   localparam logic [ADDR_W-1:0] OFFSET = ADDR_W'(INTLV_B);
   localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(BLOCK_SIZE - 1);

   logic [ADDR_W-1:0] k_q;
   logic [ADDR_W-1:0] p_q;
   logic [ADDR_W:0]   p_sum;
   logic [ADDR_W-1:0] p_next;

   // p and INTLV_A are both below BLOCK_SIZE, so one conditional subtract
   // keeps p inside the block.
   always_comb begin
      p_sum = {1'b0, p_q} + STRIDE;
      if (p_sum >= MODULUS) begin
         p_next = ADDR_W'(p_sum - MODULUS);
      end else begin
         p_next = ADDR_W'(p_sum);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q <= '0;
         p_q <= '0;
      end else if (clear) begin
         k_q <= '0;
         p_q <= OFFSET;
      end else if (advance) begin
         k_q <= k_q + ADDR_W'(1);
         p_q <= p_next;
      end
   end

   assign addr = sel_intlv ? p_q : k_q;
   assign last = (k_q == LAST_K);

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Iteration scheduler for the shared SISO engine: alternates natural and
// interleaved half-iterations, streams read addresses, handles early stop.
module turbo_iter_ctrl
   import turbo_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned ITER_W     = ITER_W_DEF,
   parameter int unsigned INTLV_A    = INTLV_A_DEF,
   parameter int unsigned INTLV_B    = INTLV_B_DEF
) (
   input  logic              clk_p_i,
   input  logic              reset_p_i,
   input  logic              start_i,
   input  logic [ITER_W-1:0] num_iter_i,
   input  logic              abort_i,
   input  logic              early_stop_i,
   output logic              siso_start_o,
   output logic              half_o,
   output logic [ITER_W-1:0] iter_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              rd_vld_o,
   input  logic              rd_rdy_i,
   input  logic              siso_done_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   state_t            state;
   logic [ITER_W-1:0] num_iter_q;
   logic [ITER_W-1:0] iter_q;
   logic              half_q;
   logic              stop_q;
   logic              err_q;
   logic              busy_q;
   logic              sstart_q;
   logic              done_q;
   logic              vld_q;

   logic              gen_clear;
   logic              gen_advance;
   logic [ADDR_W-1:0] gen_addr;
   logic              gen_last;
   logic              accept;
   logic              last_iter;
   logic              finish;

   assign accept      = vld_q && rd_rdy_i;
   assign gen_clear   = (state == ST_START);
   assign gen_advance = (state == ST_STREAM) && accept && !abort_i && !siso_done_i;
   assign last_iter   = (iter_q == num_iter_q - ITER_W'(1));
   assign finish      = half_q && (last_iter || stop_q);

   turbo_intlv_addr #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .ADDR_W     (ADDR_W),
      .INTLV_A    (INTLV_A),
      .INTLV_B    (INTLV_B)
   ) u_addr (
      .clk       (clk_p_i),
      .rst       (reset_p_i),
      .clear     (gen_clear),
      .advance   (gen_advance),
      .sel_intlv (half_q),
      .addr      (gen_addr),
      .last      (gen_last)
   );

   always_ff @(posedge clk_p_i or posedge reset_p_i) begin
      if (reset_p_i) begin
         state      <= ST_IDLE;
         num_iter_q <= '0;
         iter_q     <= '0;
         half_q     <= 1'b0;
         stop_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         sstart_q   <= 1'b0;
         done_q     <= 1'b0;
         vld_q      <= 1'b0;
      end else begin
         sstart_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start_i) begin
                  num_iter_q <= (num_iter_i == '0) ? ITER_W'(1) : num_iter_i;
                  iter_q     <= '0;
                  half_q     <= 1'b0;
                  stop_q     <= 1'b0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  sstart_q   <= 1'b1;
                  state      <= ST_START;
               end
            end
            ST_START: begin
               if (abort_i) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (siso_done_i) begin
                  err_q  <= 1'b1;
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  vld_q <= 1'b1;
                  state <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (abort_i) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  vld_q  <= 1'b0;
               end else if (siso_done_i) begin
                  err_q  <= 1'b1;
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  vld_q  <= 1'b0;
               end else if (accept && gen_last) begin
                  vld_q <= 1'b0;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (abort_i) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (siso_done_i) begin
                  // done_o must be high in the DECIDE cycle itself, so the
                  // finish decision is taken here with the live flag.
                  stop_q <= half_q && early_stop_i;
                  done_q <= half_q && (last_iter || early_stop_i);
                  state  <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               if (abort_i || finish) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (!half_q) begin
                  half_q   <= 1'b1;
                  sstart_q <= 1'b1;
                  state    <= ST_START;
               end else begin
                  half_q   <= 1'b0;
                  iter_q   <= iter_q + ITER_W'(1);
                  sstart_q <= 1'b1;
                  state    <= ST_START;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               vld_q  <= 1'b0;
            end
         endcase
      end
   end

   assign siso_start_o = sstart_q;
   assign half_o       = half_q;
   assign iter_o       = iter_q;
   assign rd_vld_o     = vld_q;
   assign rd_addr_o    = vld_q ? gen_addr : '0;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Directed bench for turbo_iter_ctrl: a scripted SISO drives the handshakes and
// every address, pulse and status value is compared against hand-derived values.
module tb_turbo_iter_ctrl;

   localparam int unsigned N  = 21;
   localparam int unsigned AW = 5;
   localparam int unsigned IW = 4;
   localparam int unsigned IA = 5;
   localparam int unsigned IB = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [IW-1:0] num_iter;
   logic          abort;
   logic          early_stop;
   logic          siso_start;
   logic          half;
   logic [IW-1:0] iter;
   logic [AW-1:0] rd_addr;
   logic          rd_vld;
   logic          rd_rdy;
   logic          siso_done;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;
   int n_starts = 0;
   int n_dones  = 0;

   always #5 clk = ~clk;

   turbo_iter_ctrl #(
      .BLOCK_SIZE (N),
      .ADDR_W     (AW),
      .ITER_W     (IW),
      .INTLV_A    (IA),
      .INTLV_B    (IB)
   ) dut (
      .clk_p_i      (clk),
      .reset_p_i    (rst),
      .start_i      (start),
      .num_iter_i   (num_iter),
      .abort_i      (abort),
      .early_stop_i (early_stop),
      .siso_start_o (siso_start),
      .half_o       (half),
      .iter_o       (iter),
      .rd_addr_o    (rd_addr),
      .rd_vld_o     (rd_vld),
      .rd_rdy_i     (rd_rdy),
      .siso_done_i  (siso_done),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   always @(negedge clk) begin
      if (siso_start === 1'b1) n_starts++;
      if (done === 1'b1) n_dones++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_addr(input int h, input int j);
      return (h != 0) ? (IB + IA * j) % N : j;
   endfunction

   // One complete decode as seen by a well-behaved SISO. stop_it: iteration whose
   // siso_done pulses carry early_stop=1; abort_it: iteration whose half-1 WAIT is
   // aborted (with a simultaneous siso_done); poke: start pulse during streaming;
   // rst_mid: asynchronous reset in the middle of the first half-1 stream.
   task automatic do_decode(input int nit, input int stop_it, input int stall,
                            input int abort_it, input int poke, input int rst_mid);
      int eff, s0, d0, cyc, idx;
      bit rdy, fin;
      eff = (nit == 0) ? 1 : nit;
      s0  = n_starts;
      d0  = n_dones;
      num_iter = IW'(nit);
      start = 1'b1;
      tick;
      start = 1'b0;
      num_iter = 4'd9;
      check("err_clr", err, 0);
      for (int it = 0; it < eff; it++) begin
         for (int h = 0; h < 2; h++) begin
            check("sstart", siso_start, 1);
            check("half", half, h);
            check("iter", iter, it);
            check("busy", busy, 1);
            tick;
            idx = 0;
            cyc = 0;
            while (idx < N && cyc < 200) begin
               rdy = (stall != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
               rd_rdy = rdy;
               if (poke != 0 && it == 0 && h == 0 && cyc == 3) start = 1'b1;
               check("rd", {rd_vld, rd_addr}, {1'b1, AW'(exp_addr(h, idx))});
               if (rst_mid != 0 && it == 0 && h == 1 && cyc == 5) begin
                  #2 rst = 1'b1;
                  #1 check("rst_async",
                           {siso_start, half, iter, rd_addr, rd_vld, busy, done, err}, 0);
                  rd_rdy = 1'b0;
                  @(negedge clk);
                  rst = 1'b0;
                  tick;
                  check("rst_idle", {busy, rd_vld, siso_start}, 0);
                  return;
               end
               tick;
               start = 1'b0;
               if (rdy) idx++;
               cyc++;
            end
            rd_rdy = 1'b0;
            check("xfers", idx, N);
            check("vld_off", rd_vld, 0);
            for (int g = 0; g < 4; g++) tick;
            early_stop = (it == stop_it);
            if (it == abort_it && h == 1) begin
               abort = 1'b1;
               siso_done = 1'b1;
               tick;
               abort = 1'b0;
               siso_done = 1'b0;
               early_stop = 1'b0;
               check("abort", {busy, rd_vld, done, err}, 0);
               check("abort_starts", n_starts - s0, 2 * it + 2);
               tick;
               check("abort_nodone", n_dones - d0, 0);
               return;
            end
            siso_done = 1'b1;
            tick;
            siso_done = 1'b0;
            early_stop = 1'b0;
            fin = (h == 1) && (it == eff - 1 || it == stop_it);
            check("done", done, fin);
            tick;
            if (fin) begin
               check("idle", {busy, done, rd_vld, siso_start}, 0);
               check("final_iter", iter, it);
               check("final_half", half, 1);
               check("n_starts", n_starts - s0, 2 * (it + 1));
               check("n_dones", n_dones - d0, 1);
               return;
            end
         end
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst = 1'b1;
      start = 1'b0;
      num_iter = '0;
      abort = 1'b0;
      early_stop = 1'b0;
      rd_rdy = 1'b0;
      siso_done = 1'b0;
      tick;
      tick;
      check("reset", {siso_start, half, iter, rd_addr, rd_vld, busy, done, err}, 0);
      rst = 1'b0;
      tick;
      check("post_reset", {siso_start, busy, rd_vld, done, err}, 0);

      do_decode(1, -1, 0, -1, 0, 0);   // single iteration, full-rate ready
      do_decode(1, -1, 1, -1, 0, 0);   // ready pattern 1,0,0,1
      do_decode(3, 1, 0, -1, 1, 0);    // early stop in iteration 1, ignored start
      do_decode(0, -1, 0, -1, 0, 0);   // zero iterations behaves as one

      // Protocol error: siso_done while streaming at k=7.
      d0 = n_dones;
      num_iter = 4'd1;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      rd_rdy = 1'b1;
      for (int i = 0; i < 7; i++) tick;
      check("err_addr", {rd_vld, rd_addr}, {1'b1, 5'd7});
      rd_rdy = 1'b0;
      siso_done = 1'b1;
      tick;
      siso_done = 1'b0;
      check("err_set", {err, busy, rd_vld, done}, 4'b1000);
      tick;
      siso_done = 1'b1;
      tick;
      siso_done = 1'b0;
      tick;
      check("err_sticky", {err, busy}, 2'b10);
      check("err_nodone", n_dones - d0, 0);
      do_decode(1, -1, 0, -1, 0, 0);

      do_decode(3, -1, 0, 2, 0, 0);    // abort in WAIT of iteration 2
      do_decode(2, -1, 0, -1, 0, 0);
      do_decode(1, -1, 0, -1, 0, 1);   // async reset mid-stream
      do_decode(1, -1, 1, -1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
